// File: rtl/uc_multicycle.sv
// Multicycle RV32I-subset control unit: Moore FSM sequencing fetch/decode/execute/mem/writeback
// plus combinational ALU-control and immediate-type decode.
module uc_multicycle #(
    parameter int ALUCTRL_W = 3,
    parameter bit EN_JAL    = 1'b1,
    parameter bit EN_ITYPE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           f3_i,
    input  logic                 f7_5_i,
    input  logic                 zero_i,
    output logic                 pc_write_o,
    output logic                 adr_src_o,
    output logic                 mem_write_o,
    output logic                 ir_write_o,
    output logic                 reg_write_o,
    output logic [1:0]           result_src_o,
    output logic [1:0]           alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [1:0]           imm_src_o,
    output logic [ALUCTRL_W-1:0] alu_ctrl_o,
    output logic                 illegal_o,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = S_FETCH;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        w_alu_op     = 2'b00;
        adr_src_o    = 1'b0;
        result_src_o = 2'b00;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_next       = S_DECODE;
                w_ir_write   = 1'b1;
                w_pc_update  = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                case (opcode_i)
                    7'd3, 7'd35: w_next = S_MEMADR;
                    7'd51:       w_next = S_EXECR;
                    7'd19:       w_next = EN_ITYPE ? S_EXECI : S_ILLEGAL;
                    7'd111:      w_next = EN_JAL ? S_JAL : S_ILLEGAL;
                    7'd99:       w_next = S_BEQ;
                    default:     w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                if (opcode_i == 7'd3)       w_next = S_MEMREAD;
                else if (opcode_i == 7'd35) w_next = S_MEMWRITE;
                else                        w_next = S_ILLEGAL;
            end
            S_MEMREAD: begin
                w_next    = S_MEMWB;
                adr_src_o = 1'b1;
            end
            S_MEMWB: begin
                result_src_o = 2'b01;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_o   = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                w_next      = S_ALUWB;
                alu_src_a_o = 2'b10;
                w_alu_op    = 2'b10;
            end
            S_EXECI: begin
                w_next      = S_ALUWB;
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                w_alu_op    = 2'b10;
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_JAL: begin
                w_next      = S_ALUWB;
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_o = 2'b10;
                w_alu_op    = 2'b01;
                w_branch    = 1'b1;
            end
            S_ILLEGAL: w_illegal = 1'b1;
            default:   w_illegal = 1'b1;
        endcase
    end

    // FETCH is the reset state, so its write strobes must be masked while reset is held
    assign pc_write_o  = (w_pc_update | (w_branch & zero_i)) & ~reset;
    assign mem_write_o = w_mem_write & ~reset;
    assign ir_write_o  = w_ir_write & ~reset;
    assign reg_write_o = w_reg_write & ~reset;
    assign illegal_o   = w_illegal & ~reset;
    assign state_o     = r_state;

    always_comb begin
        case (opcode_i)
            7'd35:   imm_src_o = 2'b01;
            7'd99:   imm_src_o = 2'b10;
            7'd111:  imm_src_o = 2'b11;
            default: imm_src_o = 2'b00;
        endcase
    end

    always_comb begin
        w_alu = 3'b000;
        case (w_alu_op)
            2'b01: w_alu = 3'b001;
            2'b10: begin
                case (f3_i)
                    3'b000:  w_alu = (opcode_i[5] & f7_5_i) ? 3'b001 : 3'b000;
                    3'b010:  w_alu = 3'b101;
                    3'b110:  w_alu = 3'b011;
                    3'b111:  w_alu = 3'b010;
                    default: w_alu = 3'b000;
                endcase
            end
            default: w_alu = 3'b000;
        endcase
    end

    assign alu_ctrl_o = ALUCTRL_W'(w_alu);

endmodule

// File: tb/tb_uc_multicycle.sv
// Directed bench for uc_multicycle: default instance plus an EN_JAL=0 instance on shared inputs.
module tb_uc_multicycle;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7_5;
    logic       zero;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state;

    logic       nj_pc_write, nj_adr_src, nj_mem_write, nj_ir_write, nj_reg_write, nj_illegal;
    logic [1:0] nj_result_src, nj_alu_src_a, nj_alu_src_b, nj_imm_src;
    logic [2:0] nj_alu_ctrl;
    logic [3:0] nj_state;

    int checks = 0;
    int errors = 0;

    uc_multicycle dut (
        .clk(clk), .reset(reset), .opcode_i(opcode), .f3_i(f3), .f7_5_i(f7_5), .zero_i(zero),
        .pc_write_o(pc_write), .adr_src_o(adr_src), .mem_write_o(mem_write), .ir_write_o(ir_write),
        .reg_write_o(reg_write), .result_src_o(result_src), .alu_src_a_o(alu_src_a),
        .alu_src_b_o(alu_src_b), .imm_src_o(imm_src), .alu_ctrl_o(alu_ctrl),
        .illegal_o(illegal), .state_o(state)
    );

    uc_multicycle #(.EN_JAL(1'b0)) dut_nj (
        .clk(clk), .reset(reset), .opcode_i(opcode), .f3_i(f3), .f7_5_i(f7_5), .zero_i(zero),
        .pc_write_o(nj_pc_write), .adr_src_o(nj_adr_src), .mem_write_o(nj_mem_write),
        .ir_write_o(nj_ir_write), .reg_write_o(nj_reg_write), .result_src_o(nj_result_src),
        .alu_src_a_o(nj_alu_src_a), .alu_src_b_o(nj_alu_src_b), .imm_src_o(nj_imm_src),
        .alu_ctrl_o(nj_alu_ctrl), .illegal_o(nj_illegal), .state_o(nj_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 7'd0; f3 = 3'd0; f7_5 = 1'b0; zero = 1'b0;
        repeat (2) tick();
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", state); end
        checks++; if (nj_state !== 4'd0) begin errors++; $display("FAIL reset_nj_state got %0d expected 0", nj_state); end
        checks++; if (ir_write !== 1'b0) begin errors++; $display("FAIL reset_ir_write got %b expected 0", ir_write); end
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL reset_pc_write got %b expected 0", pc_write); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b expected 0", illegal); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL rel_state got %0d expected 0", state); end
        checks++; if (ir_write !== 1'b1) begin errors++; $display("FAIL fetch_ir_write got %b expected 1", ir_write); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL fetch_pc_write got %b expected 1", pc_write); end
        checks++; if (alu_src_b !== 2'b10) begin errors++; $display("FAIL fetch_alu_src_b got %b expected 10", alu_src_b); end
        checks++; if (result_src !== 2'b10) begin errors++; $display("FAIL fetch_result_src got %b expected 10", result_src); end
    endtask

    task automatic test_lw();
        int seq [6];
        seq = '{0, 1, 2, 3, 4, 0};
        opcode = 7'd3;
        for (int i = 0; i < 6; i++) begin
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL lw_state[%0d] got %0d expected %0d", i, state, seq[i]); end
            checks++; if (reg_write !== (seq[i] == 4)) begin errors++; $display("FAIL lw_reg_write[%0d] got %b expected %b", i, reg_write, seq[i] == 4); end
            if (seq[i] == 4) begin
                checks++; if (result_src !== 2'b01) begin errors++; $display("FAIL lw_result_src got %b expected 01", result_src); end
            end
            if (seq[i] == 3) begin
                checks++; if (adr_src !== 1'b1) begin errors++; $display("FAIL lw_adr_src got %b expected 1", adr_src); end
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_sw();
        int seq [5];
        seq = '{0, 1, 2, 5, 0};
        opcode = 7'd35;
        for (int i = 0; i < 5; i++) begin
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL sw_state[%0d] got %0d expected %0d", i, state, seq[i]); end
            checks++; if (mem_write !== (seq[i] == 5)) begin errors++; $display("FAIL sw_mem_write[%0d] got %b expected %b", i, mem_write, seq[i] == 5); end
            checks++; if (adr_src !== (seq[i] == 5)) begin errors++; $display("FAIL sw_adr_src[%0d] got %b expected %b", i, adr_src, seq[i] == 5); end
            checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL sw_reg_write[%0d] got %b expected 0", i, reg_write); end
            if (seq[i] == 5) begin
                checks++; if (imm_src !== 2'b01) begin errors++; $display("FAIL sw_imm_src got %b expected 01", imm_src); end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_alu();
        int seq [5];
        seq = '{0, 1, 6, 7, 0};
        opcode = 7'd51; f3 = 3'b000; f7_5 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL r_state[%0d] got %0d expected %0d", i, state, seq[i]); end
            if (seq[i] == 6) begin
                checks++; if (alu_ctrl !== 3'b001) begin errors++; $display("FAIL r_sub got %b expected 001", alu_ctrl); end
                checks++; if (alu_src_a !== 2'b10 || alu_src_b !== 2'b00) begin errors++; $display("FAIL r_src got %b/%b expected 10/00", alu_src_a, alu_src_b); end
                f3 = 3'b111; #1;
                checks++; if (alu_ctrl !== 3'b010) begin errors++; $display("FAIL r_and got %b expected 010", alu_ctrl); end
                f3 = 3'b110; #1;
                checks++; if (alu_ctrl !== 3'b011) begin errors++; $display("FAIL r_or got %b expected 011", alu_ctrl); end
                f3 = 3'b010; #1;
                checks++; if (alu_ctrl !== 3'b101) begin errors++; $display("FAIL r_slt got %b expected 101", alu_ctrl); end
                f3 = 3'b001; #1;
                checks++; if (alu_ctrl !== 3'b000) begin errors++; $display("FAIL r_other got %b expected 000", alu_ctrl); end
                f3 = 3'b000;
            end
            if (seq[i] == 7) begin
                checks++; if (reg_write !== 1'b1 || result_src !== 2'b00) begin errors++; $display("FAIL r_wb got %b/%b expected 1/00", reg_write, result_src); end
            end
            if (i < 4) tick();
        end
        seq = '{0, 1, 8, 7, 0};
        opcode = 7'd19; f3 = 3'b000; f7_5 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL i_state[%0d] got %0d expected %0d", i, state, seq[i]); end
            if (seq[i] == 8) begin
                checks++; if (alu_ctrl !== 3'b000) begin errors++; $display("FAIL i_addi got %b expected 000", alu_ctrl); end
                checks++; if (alu_src_a !== 2'b10 || alu_src_b !== 2'b01) begin errors++; $display("FAIL i_src got %b/%b expected 10/01", alu_src_a, alu_src_b); end
            end
            if (i < 4) tick();
        end
        f7_5 = 1'b0;
    endtask

    task automatic test_beq();
        int seq [4];
        seq = '{0, 1, 10, 0};
        opcode = 7'd99; zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL beq_state[%0d] got %0d expected %0d", i, state, seq[i]); end
            if (seq[i] == 1) begin
                checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL beq_dec_pc_write got %b expected 0", pc_write); end
            end
            if (seq[i] == 10) begin
                checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL beq_taken got %b expected 1", pc_write); end
                checks++; if (alu_ctrl !== 3'b001) begin errors++; $display("FAIL beq_alu got %b expected 001", alu_ctrl); end
                checks++; if (imm_src !== 2'b10) begin errors++; $display("FAIL beq_imm got %b expected 10", imm_src); end
                zero = 1'b0; #1;
                checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL beq_not_taken got %b expected 0", pc_write); end
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_jal();
        int seq [5];
        int nseq [5];
        seq  = '{0, 1, 9, 7, 0};
        nseq = '{0, 1, 11, 0, 1};
        opcode = 7'd111;
        for (int i = 0; i < 5; i++) begin
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL jal_state[%0d] got %0d expected %0d", i, state, seq[i]); end
            checks++; if (nj_state !== 4'(nseq[i])) begin errors++; $display("FAIL nojal_state[%0d] got %0d expected %0d", i, nj_state, nseq[i]); end
            checks++; if (nj_illegal !== (nseq[i] == 11)) begin errors++; $display("FAIL nojal_illegal[%0d] got %b expected %b", i, nj_illegal, nseq[i] == 11); end
            if (seq[i] == 9) begin
                checks++; if (imm_src !== 2'b11) begin errors++; $display("FAIL jal_imm got %b expected 11", imm_src); end
                checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL jal_pc_write got %b expected 1", pc_write); end
                checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL jal_illegal got %b expected 0", illegal); end
            end
            if (i < 4) tick();
        end
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (state !== 4'd0 || nj_state !== 4'd0) begin errors++; $display("FAIL resync got %0d/%0d expected 0/0", state, nj_state); end
    endtask

    task automatic test_illegal();
        int seq [4];
        seq = '{0, 1, 11, 0};
        opcode = 7'd0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL ill_state[%0d] got %0d expected %0d", i, state, seq[i]); end
            checks++; if (illegal !== (seq[i] == 11)) begin errors++; $display("FAIL ill_flag[%0d] got %b expected %b", i, illegal, seq[i] == 11); end
            if (seq[i] == 11) begin
                checks++; if ({pc_write, ir_write, reg_write, mem_write} !== 4'b0000) begin errors++; $display("FAIL ill_writes got %b expected 0000", {pc_write, ir_write, reg_write, mem_write}); end
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_mid_reset();
        opcode = 7'd35;
        repeat (3) tick();
        checks++; if (state !== 4'd5 || mem_write !== 1'b1) begin errors++; $display("FAIL mr_pre got %0d/%b expected 5/1", state, mem_write); end
        reset = 1'b1;
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL mr_state got %0d expected 0", state); end
        checks++; if ({mem_write, ir_write, pc_write, reg_write} !== 4'b0000) begin errors++; $display("FAIL mr_strobes got %b expected 0000", {mem_write, ir_write, pc_write, reg_write}); end
        tick();
        checks++; if (state !== 4'd0 || mem_write !== 1'b0 || ir_write !== 1'b0) begin errors++; $display("FAIL mr_hold got %0d/%b/%b expected 0/0/0", state, mem_write, ir_write); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (state !== 4'd0 || ir_write !== 1'b1) begin errors++; $display("FAIL mr_release got %0d/%b expected 0/1", state, ir_write); end
        tick();
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL mr_resume got %0d expected 1", state); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_alu();
        test_beq();
        test_jal();
        test_illegal();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
